// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants for the instruction encoder/loader.
// Holds opcodes, immediate range limits, instruction width and the loader FSM states.
package riscv_pkg;

    localparam int INSTR_W = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Signed byte-offset limits that survive packing without truncation.
    localparam int IMM_IS_MIN = -2048;
    localparam int IMM_IS_MAX = 2047;
    localparam int IMM_B_MIN  = -4096;
    localparam int IMM_B_MAX  = 4094;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } loader_state_t;

endpackage

// File: rtl/instr_field_packer.sv
// Purely combinational RV32I field packer: opcode/register/funct/immediate
// fields in, 32-bit instruction word out. range_ok reports whether the
// immediate fits the selected format without loss (always 1 for R-type).
module instr_field_packer
    import riscv_pkg::*;
(
    input  logic [6:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic [31:0]        imm,
    output logic [INSTR_W-1:0] instr,
    output logic               range_ok
);

    logic signed [31:0] simm;

    assign simm = $signed(imm);

    // Select the bit layout by opcode; anything unrecognised packs as R-type.
    always_comb begin
        instr    = {funct7, rs2, rs1, funct3, rd, opcode};
        range_ok = 1'b1;
        case (opcode)
            OPC_LOAD: begin
                instr    = {imm[11:0], rs1, funct3, rd, opcode};
                range_ok = (simm >= IMM_IS_MIN) && (simm <= IMM_IS_MAX);
            end
            OPC_STORE: begin
                instr    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_ok = (simm >= IMM_IS_MIN) && (simm <= IMM_IS_MAX);
            end
            OPC_BRANCH: begin
                // imm[0] has no slot in the B format; an odd offset cannot be encoded.
                instr    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_ok = (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX) && !imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs field bundles into RV32I words and streams
// them, with word-aligned byte addresses, to the instruction-memory write port.
// Optional build macro IMM_RANGE_CHECK_EN: drops bundles whose immediate does
// not fit its format and raises the sticky err output (port absent otherwise).
module instr_encoder_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [31:0]        in_imm,
    input  logic               base_load,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_addr,
`ifdef IMM_RANGE_CHECK_EN
    output logic               err,
`endif
    output logic [CNT_W-1:0]   load_count
);

    loader_state_t      state, state_nxt;
    logic [INSTR_W-1:0] packed_word;
    logic               range_ok;
    logic               word_ok;
    logic               accept;
    logic               handshake;
    logic               load_word;
    logic [ADDR_W-1:0]  addr_cnt;

    instr_field_packer u_packer (
        .opcode   (in_opcode),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .funct3   (in_funct3),
        .funct7   (in_funct7),
        .imm      (in_imm),
        .instr    (packed_word),
        .range_ok (range_ok)
    );

`ifdef IMM_RANGE_CHECK_EN
    assign word_ok = range_ok;
`else
    logic unused_range_ok;
    assign unused_range_ok = range_ok;
    assign word_ok         = 1'b1;
`endif

    // Handshakes are derived from the state register and inputs only, so the
    // FSM decode below never feeds back into itself.
    assign handshake = (state == ST_FULL) && out_ready;
    assign accept    = in_valid && ((state == ST_EMPTY) || out_ready);
    assign load_word = accept && word_ok;
    assign out_addr  = addr_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_EMPTY;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs for the single-entry output slot.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (load_word) state_nxt = ST_FULL;
            end
            ST_FULL: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready && !load_word) state_nxt = ST_EMPTY;
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Capture the packed word whenever a bundle is admitted into the slot.
    always_ff @(posedge clk) begin
        if (reset)          out_instr <= '0;
        else if (load_word) out_instr <= packed_word;
    end

    // Byte address counter; base loads only while empty so a pending word keeps its address.
    always_ff @(posedge clk) begin
        if (reset)                                addr_cnt <= '0;
        else if (base_load && state == ST_EMPTY)  addr_cnt <= base_addr & ~ADDR_W'(3);
        else if (handshake)                       addr_cnt <= addr_cnt + ADDR_W'(4);
    end

    // Saturating count of words taken by memory.
    always_ff @(posedge clk) begin
        if (reset)                               load_count <= '0;
        else if (handshake && load_count != '1)  load_count <= load_count + CNT_W'(1);
    end

`ifdef IMM_RANGE_CHECK_EN
    // Sticky flag for bundles consumed but dropped because the immediate did not fit.
    always_ff @(posedge clk) begin
        if (reset)                     err <= 1'b0;
        else if (accept && !range_ok)  err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed encodings and flow
// cases followed by randomized traffic against a behavioural model.
// Honours IMM_RANGE_CHECK_EN the same way as the design.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        base_load;
    logic [11:0] base_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [11:0] out_addr;
    logic [15:0] load_count;
`ifdef IMM_RANGE_CHECK_EN
    logic        err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_full;
    logic [31:0] m_word;
    logic [11:0] m_addr;
    logic [15:0] m_count;
    bit          m_err;

    instr_encoder_loader #(.ADDR_W(12), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .base_load  (base_load),
        .base_addr  (base_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
`ifdef IMM_RANGE_CHECK_EN
        .err        (err),
`endif
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm);
        logic [31:0] common;
        common = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(opc);
        case (opc)
            7'h03: return ((imm & 32'hFFF) << 20) | common | (32'(rd) << 7);
            7'h23: return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | common
                          | ((imm & 32'h1F) << 7);
            7'h63: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                          | (32'(rs2) << 20) | common | (((imm >> 1) & 32'hF) << 8)
                          | (((imm >> 11) & 32'h1) << 7);
            default: return (32'(f7) << 25) | (32'(rs2) << 20) | common | (32'(rd) << 7);
        endcase
    endfunction

`ifdef IMM_RANGE_CHECK_EN
    function automatic bit imm_ok(input logic [6:0] opc, input logic [31:0] imm);
        int s;
        s = int'($signed(imm));
        if (opc == 7'h03 || opc == 7'h23) return (s >= -2048) && (s <= 2047);
        if (opc == 7'h63) return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        return 1'b1;
    endfunction
`endif

    task automatic set_fields(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
        in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3;  in_funct7 = f7; in_imm = imm;
    endtask

    // One clock: inputs are already applied just after a falling edge.
    task automatic tick();
        bit hs, rdy, acc, ok;
        #1;
        if (!reset) chk("in_ready", 32'(in_ready), m_full ? 32'(out_ready) : 32'd1);
        if (reset) begin
            m_full = 0; m_word = '0; m_addr = '0; m_count = '0; m_err = 0;
        end else begin
            hs  = m_full && out_ready;
            rdy = !m_full || out_ready;
            acc = in_valid && rdy;
`ifdef IMM_RANGE_CHECK_EN
            ok  = imm_ok(in_opcode, in_imm);
`else
            ok  = 1'b1;
`endif
            if (base_load && !m_full) m_addr = base_addr & 12'hFFC;
            else if (hs)              m_addr = m_addr + 12'd4;
            if (hs && m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (acc && ok) begin
                m_full = 1;
                m_word = enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
            end else if (hs) begin
                m_full = 0;
            end
            if (acc && !ok) m_err = 1;
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("out_addr", 32'(out_addr), 32'(m_addr));
        chk("load_count", 32'(load_count), 32'(m_count));
        if (m_full) chk("out_instr", out_instr, m_word);
`ifdef IMM_RANGE_CHECK_EN
        chk("err", 32'(err), 32'(m_err));
`endif
    endtask

    function automatic logic [31:0] rand_imm();
        int edges [8] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4097};
        case ($urandom_range(0, 3))
            0: return 32'(int'($urandom_range(0, 8191)) - 4096);
            1: return $urandom;
            2: return 32'(int'($urandom_range(0, 32)) - 16);
            default: return 32'(edges[$urandom_range(0, 7)]);
        endcase
    endfunction

    function automatic logic [6:0] rand_opc();
        case ($urandom_range(0, 4))
            0: return 7'h03;
            1: return 7'h23;
            2: return 7'h63;
            3: return 7'h33;
            default: return 7'($urandom);
        endcase
    endfunction

    logic [11:0] a0;

    initial begin
        reset = 1; in_valid = 0; base_load = 0; base_addr = '0; out_ready = 1;
        set_fields('0, '0, '0, '0, '0, '0, '0);
        tick(); tick();
        reset = 0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        // lw / sw / beq streamed back to back
        in_valid = 1;
        set_fields(7'h03, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8);
        tick();
        chk("lw_word", out_instr, 32'h00812283);
        chk("lw_addr", 32'(out_addr), 32'h000);
        set_fields(7'h23, 5'd0, 5'd2, 5'd6, 3'b010, 7'd0, -32'sd4);
        tick();
        chk("sw_word", out_instr, 32'hFE612E23);
        chk("lw_count", 32'(load_count), 32'd1);
        set_fields(7'h63, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd8);
        tick();
        chk("beq_word", out_instr, 32'hFE208CE3);
        in_valid = 0;
        tick();

        // Backpressure
        reset = 1; tick(); reset = 0;
        in_valid = 1; out_ready = 0;
        set_fields(7'h03, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8);
        tick();
        set_fields(7'h23, 5'd0, 5'd2, 5'd6, 3'b010, 7'd0, -32'sd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_word", out_instr, 32'h00812283);
            chk("bp_hold_addr", 32'(out_addr), 32'h000);
        end
        out_ready = 1;
        tick();
        chk("bp_second_word", out_instr, 32'hFE612E23);
        chk("bp_second_addr", 32'(out_addr), 32'h004);
        in_valid = 0;
        tick();

        // Base load and address wrap
        base_load = 1; base_addr = 12'hFFB; in_valid = 1;
        set_fields(7'h03, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8);
        tick();
        chk("base_addr0", 32'(out_addr), 32'hFF8);
        base_load = 0;
        tick();
        chk("base_addr1", 32'(out_addr), 32'hFFC);
        base_load = 1; base_addr = 12'h100;
        tick();
        chk("base_wrap", 32'(out_addr), 32'h000);
        base_load = 0; in_valid = 0;
        tick();

        // Out-of-range immediate
        a0 = out_addr;
        in_valid = 1;
        set_fields(7'h03, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd2048);
        tick();
`ifdef IMM_RANGE_CHECK_EN
        chk("range_drop", 32'(out_valid), 32'd0);
        chk("range_err", 32'(err), 32'd1);
`else
        chk("range_trunc", out_instr, 32'h80012283);
`endif
        set_fields(7'h03, 5'd5, 5'd2, 5'd0, 3'b010, 7'd0, 32'd8);
        tick();
`ifdef IMM_RANGE_CHECK_EN
        chk("range_next_addr", 32'(out_addr), 32'(a0));
`else
        chk("range_next_addr", 32'(out_addr), 32'(a0 + 12'd4));
`endif
        in_valid = 0;
        tick();

        // Reset while FULL
        in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0; reset = 1;
        tick();
        chk("rfull_valid", 32'(out_valid), 32'd0);
        chk("rfull_addr", 32'(out_addr), 32'd0);
        chk("rfull_count", 32'(load_count), 32'd0);
        chk("rfull_instr", out_instr, 32'd0);
        reset = 0; out_ready = 1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            base_load = ($urandom_range(0, 15) == 0);
            base_addr = 12'($urandom);
            set_fields(rand_opc(), 5'($urandom), 5'($urandom), 5'($urandom),
                       3'($urandom), 7'($urandom), rand_imm());
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the core's immediate/field decode path: packs opcode, register, funct and immediate fields into 32-bit RV32I instruction words.
- Streams packed words with byte addresses to the instruction-memory write port, so test programs can be loaded from field-level stimulus.
- Sits between a bench/host program source and instruction memory. It is never in the processor's execute path.

Parameters:
- ADDR_W, 12, width of the byte address driven to instruction memory; address wraps modulo 2^ADDR_W.
- CNT_W, 16, width of the accepted-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_opcode  in  7  instruction opcode.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field; R-type only.
- in_imm  in  32  signed immediate, two's complement, unscaled byte offset.
- base_load  in  1  load base_addr into the address counter.
- base_addr  in  ADDR_W  start byte address; bits [1:0] ignored (forced 0).
- out_valid  out  1  packed word valid.
- out_ready  in  1  memory accepts the word.
- out_instr  out  32  packed instruction.
- out_addr  out  ADDR_W  byte address for out_instr; word aligned.
- load_count  out  CNT_W  number of words accepted by memory.
- err  out  1  sticky immediate-range error; only present with the optional feature.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_addr=0, load_count=0, err=0. in_ready=1 after reset.
- Single-entry output register with a two-state FSM:
  - EMPTY: in_ready=1. in_valid moves to FULL next cycle and registers the packed word. Latency is 1 cycle.
  - FULL: out_valid=1. out_instr and out_addr are held stable until out_ready.
  - in_ready = EMPTY or (FULL and out_ready). This allows a back-to-back flow of 1 word/cycle.
  - FULL with out_ready and no new accept: go to EMPTY.
  - FULL with out_ready and in_valid (and in_ready): stay FULL with the new word.
- Address counter: increments by 4 on each out_valid & out_ready handshake. Wraps from 2^ADDR_W-4 to 0.
- The address used for the word currently in FULL is the counter value at its handshake. out_addr is always the counter itself.
- load_count increments on each handshake and saturates at all-ones.
- base_load:
  - Allowed only in EMPTY. Loads the counter with {base_addr[ADDR_W-1:2],2'b00}.
  - Ignored in FULL, so a pending word keeps its address.
  - If base_load and in_valid arrive in the same EMPTY cycle, the load takes effect first and the accepted word uses the new base.
- Packing, by opcode:
  - 0000011 I-load: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
  - 0100011 S: [31:25]=imm[11:5], [24:20]=rs2, rs1, funct3, [11:7]=imm[4:0].
  - 1100011 B: [31]=imm[12], [30:25]=imm[10:5], rs2, rs1, funct3, [11:8]=imm[4:1], [7]=imm[11]. imm[0] is dropped.
  - Any other opcode: R-type, {funct7, rs2, rs1, funct3, rd}; in_imm is ignored.
  - [6:0]=opcode in every case.
- Unused upper immediate bits are truncated.
- A reset mid-transfer drops any pending word; the counter returns to 0.

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined:
  - A bundle is out of range if its I/S imm is not in [-2048, 2047], or its B imm is not in [-4096, 4094], or its B imm is odd.
  - An out-of-range bundle is consumed (in_ready handshake completes) but never enters FULL; no word or address is consumed.
  - err is set and stays set until reset.
- Undefined: no check, silent truncation. The err port is omitted from the module.

Decomposition:
- Shared package riscv_pkg: opcode constants OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP; immediate range limits; instruction width 32.
- One natural sub-module: instr_field_packer. It is purely combinational: fields in, 32-bit word out, plus range_ok.
- The parent module holds the FSM, counter, handshake and err.

Test Plan:
- lw x5,8(x2): opcode 0000011, rd 5, f3 010, rs1 2, imm 8, base 0, out_ready=1 -> out_instr 0x00812283 at out_addr 0x000 one cycle later; load_count 1.
- sw x6,-4(x2): opcode 0100011, rs2 6, rs1 2, f3 010, imm -4 -> 0xFE612E23. beq x1,x2,-8: opcode 1100011, rs1 1, rs2 2, f3 000, imm -8 -> 0xFE208CE3.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> in_ready=0, out_instr/out_addr stable. Release -> words at 0x000 and 0x004 on consecutive cycles.
- base_load 0xFF8 (ADDR_W 12), then 3 words streamed -> addresses 0xFF8, 0xFFC, 0x000. base_load issued while FULL -> ignored.
- IMM_RANGE_CHECK_EN defined: lw with imm 2048 -> no out_valid, err=1, load_count unchanged. Next a valid bundle -> emitted at the same address. Without the macro, the same stimulus -> 0x80012283 emitted (0x800 truncated into imm[11:0]).
- Reset asserted while FULL -> next cycle out_valid=0, out_addr 0, load_count 0, err 0.
